wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the in-order pipeline and sole driver of the register file write port (ad3/wd3/we3). Accepts retiring instructions from the MEM stage over a valid/ready handshake. Holds loads until the data-memory response arrives, then extracts and sign/zero-extends the load data. Issues exactly one registered register-file write per retired instruction that writes rd.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  1  MEM stage presents an instruction
- m_ready  out  1  stage can accept; equals (state == IDLE)
- m_rd  in  5  destination register
- m_we  in  1  instruction writes rd
- m_is_load  in  1  instruction is a load
- m_funct3  in  3  load size/sign code
- m_addr_lo  in  2  load byte offset (addr[1:0])
- m_result  in  XLEN  ALU/CSR/link result for non-loads
- dm_rvalid  in  1  load data valid, one-cycle pulse
- dm_rdata  in  XLEN  raw aligned load word
- rf_ad3  out  5  register file write address
- rf_wd3  out  XLEN  register file write data
- rf_we3  out  1  register file write enable
- retire_valid  out  1  one-cycle pulse per retired instruction
- load_pending  out  1  high while in WAIT_LOAD
- Under WB_BYPASS_EN only: rs1_addr, rs2_addr in 5; rf_rd1, rf_rd2 in XLEN; rs1_data, rs2_data out XLEN

## Operation
- FSM states: IDLE, WAIT_LOAD.
- IDLE, accept (m_valid & m_ready), non-load: next cycle rf_we3 = m_we & (m_rd != 0), rf_ad3 = m_rd, rf_wd3 = m_result, retire_valid = 1. State stays IDLE.
- IDLE, accept, load: latch rd, we, funct3, addr_lo. Go to WAIT_LOAD. No write or retire yet.
- WAIT_LOAD: m_ready = 0. On dm_rvalid, compute shifted = dm_rdata >> (8*addr_lo). Extension by funct3:
  - 000 LB: sign-extend bits [7:0]
  - 001 LH: sign-extend bits [15:0]
  - 100 LBU: zero-extend bits [7:0]
  - 101 LHU: zero-extend bits [15:0]
  - 010 and all other codes: unshifted dm_rdata
- Next cycle after dm_rvalid: write with the latched rd/we (x0 suppressed), retire_valid = 1, return to IDLE.
- dm_rvalid in IDLE is ignored.
- rf_we3, rf_ad3, rf_wd3 and retire_valid are registered. When no write issues they return to 0 the following cycle; rf_ad3 and rf_wd3 hold their last value.
- Writes to x0 never assert rf_we3, but the instruction still retires.

## Timing
- Reset values: rf_we3 = 0, rf_ad3 = 0, rf_wd3 = 0, retire_valid = 0, state IDLE, m_ready = 1, load_pending = 0.
- Non-load latency: accept in cycle N, write and retire in cycle N+1. Sustains 1 instruction per cycle.
- Load latency: accept in N, dm_rvalid in M (M ≥ N+1), write in M+1. m_ready returns to 1 in M+1, so a new accept can occur in M+1.
- Reset asserted mid-load: immediate return to IDLE, no write. A dm_rvalid arriving after reset release is ignored.
- m_valid without m_ready: inputs are held by MEM and not sampled.

## Configuration
- WB_BYPASS_EN defined: combinational forwarding from the write currently on the port.
  - rs1_data = rf_wd3 when rf_we3 & (rf_ad3 == rs1_addr) & (rs1_addr != 0); otherwise rf_rd1. rs2_data is the same with rs2_addr/rf_rd2.
  - This covers the register file's same-cycle write/read hazard.
- WB_BYPASS_EN undefined: bypass ports absent. Decode stalls one cycle on a rd match with rf_ad3 while rf_we3 is high.

## Test plan
- After reset release: outputs at reset values. Accept ADD with m_rd = 5, m_result = 0x1234 -> next cycle rf_we3 = 1, rf_ad3 = 5, rf_wd3 = 0x1234, retire_valid = 1.
- Back-to-back non-loads rd = 1, 2, 3 on consecutive cycles -> three consecutive writes, m_ready stays 1.
- LB with addr_lo = 2, dm_rdata = 0x00800000, dm_rvalid 3 cycles after accept -> m_ready low for 3 cycles, then rf_wd3 = 0xFFFFFF80. Same stimulus with LBU -> 0x00000080.
- Accept with m_rd = 0, m_we = 1 -> rf_we3 stays 0, retire_valid = 1.
- rst_n pulsed low while in WAIT_LOAD, then dm_rvalid -> no write, m_ready = 1, load_pending = 0.
- WB_BYPASS_EN: rf_we3 to x7 with 0xA5A5A5A5, rs1_addr = 7, rf_rd1 = 0 -> rs1_data = 0xA5A5A5A5. rs2_addr = 0 -> rs2_data = rf_rd2.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM -> WB retire handshake: instruction payload with valid/ready.
interface wb_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            m_valid;
  logic            m_ready;
  logic [4:0]      m_rd;
  logic            m_we;
  logic            m_is_load;
  logic [2:0]      m_funct3;
  logic [1:0]      m_addr_lo;
  logic [XLEN-1:0] m_result;

  modport master (
    output m_valid, m_rd, m_we, m_is_load, m_funct3, m_addr_lo, m_result,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_rd, m_we, m_is_load, m_funct3, m_addr_lo, m_result,
    output m_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires MEM instructions, waits for load data, drives the RF write port.
// Optional WB_BYPASS_EN adds combinational forwarding of the write on the port to rs1/rs2 reads.
module wb_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_stage_if.slave       mem,
  input  logic            dm_rvalid,
  input  logic [XLEN-1:0] dm_rdata,
  output logic [4:0]      rf_ad3,
  output logic [XLEN-1:0] rf_wd3,
  output logic            rf_we3,
  output logic            retire_valid,
  output logic            load_pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
`endif
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t     state;
  logic [4:0] ld_rd;
  logic       ld_we;
  logic [2:0] ld_funct3;
  logic [1:0] ld_addr_lo;

  assign mem.m_ready  = (state == IDLE);
  assign load_pending = (state == WAIT_LOAD);

  // Align the addressed byte/halfword to bit 0, then extend by load type.
  function automatic logic [XLEN-1:0] extract_load(input logic [2:0]      f3,
                                                   input logic [1:0]      lo,
                                                   input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] sh;
    sh = raw >> {lo, 3'b000};
    case (f3)
      3'b000:  extract_load = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  extract_load = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  extract_load = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  extract_load = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: extract_load = raw;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rf_we3       <= 1'b0;
      rf_ad3       <= 5'd0;
      rf_wd3       <= '0;
      retire_valid <= 1'b0;
      ld_rd        <= 5'd0;
      ld_we        <= 1'b0;
      ld_funct3    <= 3'd0;
      ld_addr_lo   <= 2'd0;
    end else begin
      rf_we3       <= 1'b0;
      retire_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mem.m_valid) begin
            if (mem.m_is_load) begin
              ld_rd      <= mem.m_rd;
              ld_we      <= mem.m_we;
              ld_funct3  <= mem.m_funct3;
              ld_addr_lo <= mem.m_addr_lo;
              state      <= WAIT_LOAD;
            end else begin
              rf_we3       <= mem.m_we & (mem.m_rd != 5'd0);
              rf_ad3       <= mem.m_rd;
              rf_wd3       <= mem.m_result;
              retire_valid <= 1'b1;
            end
          end
        end
        WAIT_LOAD: begin
          if (dm_rvalid) begin
            rf_we3       <= ld_we & (ld_rd != 5'd0);
            rf_ad3       <= ld_rd;
            rf_wd3       <= extract_load(ld_funct3, ld_addr_lo, dm_rdata);
            retire_valid <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write on the port so decode never reads stale data in the same cycle.
  assign rs1_data = (rf_we3 && (rf_ad3 == rs1_addr) && (rs1_addr != 5'd0)) ? rf_wd3 : rf_rd1;
  assign rs2_data = (rf_we3 && (rf_ad3 == rs2_addr) && (rs2_addr != 5'd0)) ? rf_wd3 : rf_rd2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized ALU/load traffic.
module tb_wb_stage;
  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            dm_rvalid;
  logic [XLEN-1:0] dm_rdata;
  logic [4:0]      rf_ad3;
  logic [XLEN-1:0] rf_wd3;
  logic            rf_we3;
  logic            retire_valid;
  logic            load_pending;
`ifdef WB_BYPASS_EN
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rs1_data, rs2_data;
`endif

  int vectors;
  int miscompares;

  wb_stage_if #(.XLEN(XLEN)) mem_if ();

  wb_stage #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mem_if),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .rf_ad3       (rf_ad3),
    .rf_wd3       (rf_wd3),
    .rf_we3       (rf_we3),
    .retire_valid (retire_valid),
    .load_pending (load_pending)
`ifdef WB_BYPASS_EN
    ,
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rf_rd1       (rf_rd1),
    .rf_rd2       (rf_rd2),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load semantics computed arithmetically from the load rules.
  function automatic logic [31:0] ref_load(input int f3, input int lo, input logic [31:0] raw);
    longint unsigned v;
    v = longint'(raw) / (longint'(1) << (8 * lo));
    case (f3)
      0: begin v = v % 256;   if (v >= 128)   v = v + 64'hFFFF_FF00; end
      1: begin v = v % 65536; if (v >= 32768) v = v + 64'hFFFF_0000; end
      4: v = v % 256;
      5: v = v % 65536;
      default: v = longint'(raw);
    endcase
    return 32'(v);
  endfunction

  task automatic send_alu(input int rd, input bit we, input logic [31:0] res);
    check("alu_m_ready", 32'(mem_if.m_ready), 32'd1);
    mem_if.m_valid   = 1'b1;
    mem_if.m_is_load = 1'b0;
    mem_if.m_rd      = 5'(rd);
    mem_if.m_we      = we;
    mem_if.m_result  = res;
    mem_if.m_funct3  = 3'($urandom_range(7));
    mem_if.m_addr_lo = 2'($urandom_range(3));
    @(posedge clk); #1;
    mem_if.m_valid = 1'b0;
    check("alu_retire", 32'(retire_valid), 32'd1);
    check("alu_we3", 32'(rf_we3), 32'(we && rd != 0));
    if (we && rd != 0) begin
      check("alu_ad3", 32'(rf_ad3), 32'(rd));
      check("alu_wd3", rf_wd3, res);
    end
  endtask

  task automatic send_load(input int rd, input bit we, input int f3, input int lo,
                           input logic [31:0] raw, input int delay);
    logic [31:0] exp;
    exp = ref_load(f3, lo, raw);
    check("ld_m_ready_pre", 32'(mem_if.m_ready), 32'd1);
    mem_if.m_valid   = 1'b1;
    mem_if.m_is_load = 1'b1;
    mem_if.m_rd      = 5'(rd);
    mem_if.m_we      = we;
    mem_if.m_funct3  = 3'(f3);
    mem_if.m_addr_lo = 2'(lo);
    mem_if.m_result  = $urandom;
    @(posedge clk); #1;
    mem_if.m_valid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      check("ld_wait_ready", 32'(mem_if.m_ready), 32'd0);
      check("ld_wait_pending", 32'(load_pending), 32'd1);
      check("ld_wait_retire", 32'(retire_valid), 32'd0);
      check("ld_wait_we3", 32'(rf_we3), 32'd0);
      if (i == delay - 1) begin
        dm_rvalid = 1'b1;
        dm_rdata  = raw;
      end
      @(posedge clk); #1;
    end
    dm_rvalid = 1'b0;
    check("ld_retire", 32'(retire_valid), 32'd1);
    check("ld_we3", 32'(rf_we3), 32'(we && rd != 0));
    check("ld_m_ready_post", 32'(mem_if.m_ready), 32'd1);
    check("ld_pending_post", 32'(load_pending), 32'd0);
    if (we && rd != 0) begin
      check("ld_ad3", 32'(rf_ad3), 32'(rd));
      check("ld_wd3", rf_wd3, exp);
    end
  endtask

  // Idle cycle with stray dm_rvalid noise, which must be ignored.
  task automatic idle_cycle();
    dm_rvalid = 1'($urandom_range(1));
    dm_rdata  = $urandom;
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    check("idle_retire", 32'(retire_valid), 32'd0);
    check("idle_we3", 32'(rf_we3), 32'd0);
    check("idle_ready", 32'(mem_if.m_ready), 32'd1);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst_n            = 1'b0;
    dm_rvalid        = 1'b0;
    dm_rdata         = '0;
    mem_if.m_valid   = 1'b0;
    mem_if.m_rd      = '0;
    mem_if.m_we      = 1'b0;
    mem_if.m_is_load = 1'b0;
    mem_if.m_funct3  = '0;
    mem_if.m_addr_lo = '0;
    mem_if.m_result  = '0;
`ifdef WB_BYPASS_EN
    rs1_addr = '0; rs2_addr = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_we3", 32'(rf_we3), 32'd0);
    check("rst_ad3", 32'(rf_ad3), 32'd0);
    check("rst_wd3", rf_wd3, 32'd0);
    check("rst_retire", 32'(retire_valid), 32'd0);
    check("rst_ready", 32'(mem_if.m_ready), 32'd1);
    check("rst_pending", 32'(load_pending), 32'd0);

    send_alu(5, 1'b1, 32'h0000_1234);
    idle_cycle();
    send_alu(1, 1'b1, 32'h1111_0001);
    send_alu(2, 1'b1, 32'h2222_0002);
    send_alu(3, 1'b1, 32'h3333_0003);
    send_alu(0, 1'b1, 32'hDEAD_BEEF);
    idle_cycle();

    send_load(9, 1'b1, 0, 2, 32'h0080_0000, 3);
    send_load(9, 1'b1, 4, 2, 32'h0080_0000, 3);
    send_load(10, 1'b1, 1, 2, 32'h8001_0000, 1);
    send_load(11, 1'b1, 5, 2, 32'h8001_0000, 2);
    send_load(12, 1'b1, 2, 3, 32'hCAFE_F00D, 1);
    send_load(0, 1'b1, 0, 0, 32'h0000_00FF, 2);
    send_alu(4, 1'b1, 32'h4444_4444);

    // Reset during WAIT_LOAD drops the load; a late dm_rvalid is ignored.
    mem_if.m_valid = 1'b1; mem_if.m_is_load = 1'b1;
    mem_if.m_rd = 5'd13; mem_if.m_we = 1'b1; mem_if.m_funct3 = 3'd2;
    @(posedge clk); #1;
    mem_if.m_valid = 1'b0;
    check("mid_pending", 32'(load_pending), 32'd1);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("mid_ready", 32'(mem_if.m_ready), 32'd1);
    check("mid_pending_clr", 32'(load_pending), 32'd0);
    dm_rvalid = 1'b1; dm_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    check("mid_retire", 32'(retire_valid), 32'd0);
    check("mid_we3", 32'(rf_we3), 32'd0);

`ifdef WB_BYPASS_EN
    send_alu(7, 1'b1, 32'hA5A5_A5A5);
    rs1_addr = 5'd7; rf_rd1 = 32'h0; rs2_addr = 5'd0; rf_rd2 = $urandom;
    #1;
    check("byp_rs1", rs1_data, 32'hA5A5_A5A5);
    check("byp_rs2_x0", rs2_data, rf_rd2);
    rs2_addr = 5'd8;
    #1;
    check("byp_rs2_miss", rs2_data, rf_rd2);
    @(posedge clk); #1;
    check("byp_rs1_stale", rs1_data, rf_rd1);
`endif

    for (int n = 0; n < 80; n++) begin
      int          rd, f3, lo, dly;
      bit          we;
      logic [31:0] d;
      rd  = int'($urandom_range(31));
      we  = 1'($urandom_range(1));
      f3  = int'($urandom_range(7));
      lo  = int'($urandom_range(3));
      dly = int'($urandom_range(4, 1));
      d   = $urandom;
      case ($urandom_range(2))
        0:       send_alu(rd, we, d);
        1:       send_load(rd, we, f3, lo, d, dly);
        default: idle_cycle();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
